// File: rtl/ram_dp_arbiter.sv
// ram_dp_arbiter
// ---------------------------------------------------------------------------
// Round-robin arbiter that shares one true dual-port RAM among NumReq
// requesters. Each cycle it picks up to two requests: the first valid one
// in search order goes to port A, and the next compatible one goes to port B.
// Read responses come back a fixed RdLat cycles after the grant. They are
// steered to the issuing requester by a small {valid, id} shift register on
// each port.
//
// Parameters
//   NumReq     number of requesters (2..8)
//   AddrWidth  RAM address width
//   DataWidth  RAM data width
//   Pipelined  0/1; must match the RAM instance, read latency = 1 + Pipelined
//
// Ports
//   clk_i                       common clock shared with the RAM
//   rst_i                       synchronous active-high reset
//   req_valid_i  [NumReq]       request pending per requester
//   req_ready_o  [NumReq]       request accepted this cycle
//   req_we_i     [NumReq]       1 = write, 0 = read
//   req_addr_i   [NumReq*AW]    flattened addresses, slice i = requester i
//   req_data_i   [NumReq*DW]    flattened write data
//   rsp_valid_o  [NumReq]       read data valid pulse
//   rsp_data_o   [NumReq*DW]    flattened read data, meaningful with valid
//   ram_re_*_o / ram_we_*_o     RAM port read / write enables
//   ram_addr_*_o                RAM port address (read and write)
//   ram_data_*_o                RAM port write data
//   ram_data_*_i                RAM port read data
// ---------------------------------------------------------------------------
module ram_dp_arbiter #(
  parameter int NumReq    = 4,
  parameter int AddrWidth = 16,
  parameter int DataWidth = 32,
  parameter int Pipelined = 0
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NumReq-1:0]             req_valid_i,
  output logic [NumReq-1:0]             req_ready_o,
  input  logic [NumReq-1:0]             req_we_i,
  input  logic [NumReq*AddrWidth-1:0]   req_addr_i,
  input  logic [NumReq*DataWidth-1:0]   req_data_i,
  output logic [NumReq-1:0]             rsp_valid_o,
  output logic [NumReq*DataWidth-1:0]   rsp_data_o,
  output logic                          ram_re_a_o,
  output logic                          ram_re_b_o,
  output logic                          ram_we_a_o,
  output logic                          ram_we_b_o,
  output logic [AddrWidth-1:0]          ram_addr_a_o,
  output logic [AddrWidth-1:0]          ram_addr_b_o,
  output logic [DataWidth-1:0]          ram_data_a_o,
  output logic [DataWidth-1:0]          ram_data_b_o,
  input  logic [DataWidth-1:0]          ram_data_a_i,
  input  logic [DataWidth-1:0]          ram_data_b_i
);

  localparam int IdW   = (NumReq > 1) ? $clog2(NumReq) : 1;
  localparam int RdLat = 1 + Pipelined;

  genvar gi;

  // -------------------------------------------------------------------------
  // Unpack the flattened request buses into per-requester arrays
  // -------------------------------------------------------------------------
  logic [AddrWidth-1:0] addr_arr  [NumReq];
  logic [DataWidth-1:0] wdata_arr [NumReq];

  for (gi = 0; gi < NumReq; gi++) begin : g_unpack
    assign addr_arr[gi]  = req_addr_i[gi*AddrWidth +: AddrWidth];
    assign wdata_arr[gi] = req_data_i[gi*DataWidth +: DataWidth];
  end

  // (base + off) modulo NumReq; off never exceeds NumReq-1, so one
  // conditional subtraction is enough.
  function automatic logic [IdW-1:0] wrap_inc(input logic [IdW-1:0] base,
                                              input int              off);
    int sum;
    sum = int'(base) + off;
    if (sum >= NumReq) sum = sum - NumReq;
    return IdW'(sum);
  endfunction

  // -------------------------------------------------------------------------
  // Round-robin pointer and grant selection
  // -------------------------------------------------------------------------
  logic [IdW-1:0] ptr_reg, ptr_next;
  logic           grant_a, grant_b;
  logic [IdW-1:0] id_a, id_b;

  // Walk the search order once. The first valid requester takes port A. Every
  // later valid requester is a B candidate until one survives the hazard
  // check: same address with either side writing is never co-granted.
  always_comb begin
    logic [IdW-1:0] cand;
    grant_a = 1'b0;
    grant_b = 1'b0;
    id_a    = '0;
    id_b    = '0;
    cand    = '0;
    for (int k = 0; k < NumReq; k++) begin
      cand = wrap_inc(ptr_reg, k);
      if (req_valid_i[cand]) begin
        if (!grant_a) begin
          grant_a = 1'b1;
          id_a    = cand;
        end else if (!grant_b &&
                     !((addr_arr[cand] == addr_arr[id_a]) &&
                       (req_we_i[cand] || req_we_i[id_a]))) begin
          grant_b = 1'b1;
          id_b    = cand;
        end
      end
    end
  end

  // Priority moves to one past the last requester that was served.
  always_comb begin
    ptr_next = ptr_reg;
    if (grant_b) begin
      ptr_next = wrap_inc(id_b, 1);
    end else if (grant_a) begin
      ptr_next = wrap_inc(id_a, 1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_reg <= '0;
    end else begin
      ptr_reg <= ptr_next;
    end
  end

  // -------------------------------------------------------------------------
  // Per-port command drive (index 0 = port A, 1 = port B)
  // -------------------------------------------------------------------------
  logic [1:0]           port_gnt;
  logic [IdW-1:0]       port_id   [2];
  logic [1:0]           port_re;
  logic [1:0]           port_we;
  logic [AddrWidth-1:0] port_addr [2];
  logic [DataWidth-1:0] port_data [2];

  // Reset masks every grant so the RAM and requesters see an idle block.
  assign port_gnt   = {grant_b, grant_a} & {2{~rst_i}};
  assign port_id[0] = id_a;
  assign port_id[1] = id_b;

  for (gi = 0; gi < 2; gi++) begin : g_port
    assign port_we[gi]   = port_gnt[gi] &  req_we_i[port_id[gi]];
    assign port_re[gi]   = port_gnt[gi] & ~req_we_i[port_id[gi]];
    assign port_addr[gi] = port_gnt[gi] ? addr_arr[port_id[gi]]  : '0;
    assign port_data[gi] = port_gnt[gi] ? wdata_arr[port_id[gi]] : '0;
  end

  assign ram_re_a_o   = port_re[0];
  assign ram_re_b_o   = port_re[1];
  assign ram_we_a_o   = port_we[0];
  assign ram_we_b_o   = port_we[1];
  assign ram_addr_a_o = port_addr[0];
  assign ram_addr_b_o = port_addr[1];
  assign ram_data_a_o = port_data[0];
  assign ram_data_b_o = port_data[1];

  // A and B never share an id, so the two writes below never collide.
  always_comb begin
    req_ready_o = '0;
    if (port_gnt[0]) req_ready_o[id_a] = 1'b1;
    if (port_gnt[1]) req_ready_o[id_b] = 1'b1;
  end

  // -------------------------------------------------------------------------
  // Read-response tracking: RdLat-deep {valid, id} pipe per port
  // -------------------------------------------------------------------------
  logic [1:0]     tail_vld;
  logic [IdW-1:0] tail_id [2];

  for (gi = 0; gi < 2; gi++) begin : g_trk
    logic [RdLat-1:0] vld_reg;
    logic [IdW-1:0]   id_reg [RdLat];

    always_ff @(posedge clk_i) begin
      // Clearing the valids drops any reads still in flight.
      if (rst_i) begin
        vld_reg <= '0;
      end else begin
        vld_reg[0] <= port_re[gi];
        for (int s = 1; s < RdLat; s++) begin
          vld_reg[s] <= vld_reg[s-1];
        end
      end
      // Ids only matter alongside a valid bit, so they need no reset.
      id_reg[0] <= port_id[gi];
      for (int s = 1; s < RdLat; s++) begin
        id_reg[s] <= id_reg[s-1];
      end
    end

    assign tail_vld[gi] = vld_reg[RdLat-1] & ~rst_i;
    assign tail_id[gi]  = id_reg[RdLat-1];
  end

  // Route each port's read data to the requester named at its tail.
  for (gi = 0; gi < NumReq; gi++) begin : g_rsp
    logic hit_a, hit_b;
    assign hit_a = tail_vld[0] && (tail_id[0] == IdW'(gi));
    assign hit_b = tail_vld[1] && (tail_id[1] == IdW'(gi));
    assign rsp_valid_o[gi] = hit_a | hit_b;
    assign rsp_data_o[gi*DataWidth +: DataWidth] =
      hit_a ? ram_data_a_i : (hit_b ? ram_data_b_i : '0);
  end

endmodule

// File: doc/ram_dp_arbiter.md
# ram_dp_arbiter

Round-robin arbiter that shares one true dual-port RAM (`RAM_DP_RW`) among `NumReq` requesters with valid/ready handshakes. Each cycle it grants up to two requests, one to port A and one to port B, and blocks hazardous same-address pairs. It tracks read latency (1 or 2 cycles, per `Pipelined`) and routes read data back to the issuing requester. It sits between compute-side clients (PE buffers, DMA) and the RAM wrapper.

## Interface

Parameters:
- `NumReq`, 4: number of requesters (2..8).
- `AddrWidth`, 16: RAM address width.
- `DataWidth`, 32: RAM data width.
- `Pipelined`, 0: must match the RAM instance. Read latency `RdLat = 1 + Pipelined`.

Ports:
- `clk_i`  in  1  common clock, shared with the RAM.
- `rst_i`  in  1  synchronous reset, active-high.
- `req_valid_i`  in  NumReq  request pending, one bit per requester.
- `req_ready_o`  out  NumReq  request granted this cycle.
- `req_we_i`  in  NumReq  1 = write, 0 = read.
- `req_addr_i`  in  NumReq*AddrWidth  flattened addresses; requester i uses slice i.
- `req_data_i`  in  NumReq*DataWidth  flattened write data.
- `rsp_valid_o`  out  NumReq  read data valid, one-cycle pulse.
- `rsp_data_o`  out  NumReq*DataWidth  flattened read data; a slice is valid only with its `rsp_valid_o` bit.
- `ram_re_a_o`, `ram_re_b_o`  out  1  RAM read enables.
- `ram_we_a_o`, `ram_we_b_o`  out  1  RAM write enables.
- `ram_addr_a_o`, `ram_addr_b_o`  out  AddrWidth  port address; drives both the read and write address of that port.
- `ram_data_a_o`, `ram_data_b_o`  out  DataWidth  RAM write data.
- `ram_data_a_i`, `ram_data_b_i`  in  DataWidth  RAM read data.

## Operation

- Round-robin pointer `ptr` (0..NumReq-1) names the highest-priority requester. The search order is `ptr, ptr+1, …` modulo NumReq.
- **Grant A:** the first valid requester in search order.
- **Grant B:** the next valid requester after A in search order, subject to the conflict rule.
- **Conflict rule:** the B candidate is skipped (not granted) if its address equals A's and either request is a write. The search then continues to the following candidate.
  - Two reads to the same address are both granted.
- A requester is granted at most once per cycle. `req_ready_o[i] = 1` means that request is accepted this cycle.
- **RAM drive:** granted port gets `re = ~we`, `we = we`, and the requester's address and data. An ungranted port gets re/we = 0. Its address and data outputs are don't-care but driven to 0.
- **Pointer update:**
  - If any grant occurred, `ptr` moves to one past the last granted requester (B if granted, else A), modulo NumReq.
  - If no grant occurred, `ptr` holds.
- **Response tracking:** per port, a `RdLat`-deep shift register of {valid, requester id}, loaded on read grants.
  - At the tail, `rsp_valid_o[id]` is set and the slice is muxed from the matching `ram_data_*_i`.
  - A and B tails never target the same id in one cycle, because a requester is granted at most once per cycle.
- Responses per requester return in issue order. The latency is fixed, so no reorder logic is needed.
- Writes produce no response.

## Timing

- Grant logic is combinational from `req_*_i` and `ptr`. `req_ready_o` and the `ram_*_o` command outputs are valid in the same cycle. The RAM samples on the next `clk_i` edge.
- A read granted in cycle T has `rsp_valid_o` high in cycle T+RdLat, and is combinational off that cycle's `ram_data_*_i`.
- Back-to-back grants to one requester are allowed every cycle. Up to `RdLat` reads may be in flight per port.
- Requesters must hold valid/we/addr/data stable until ready. Dropping valid before ready is illegal; the block need not handle it.
- **Reset (synchronous, `rst_i`=1 at an edge):**
  - `ptr` = 0 and all tracking valids = 0.
  - During reset cycles, `req_ready_o` = 0, all `ram_re/we` = 0, and `rsp_valid_o` = 0.
  - In-flight reads at reset are dropped; no response is issued.
- **Edge cases:**
  - No valid requests: both ports idle.
  - Exactly one valid request: port A only.
  - Pointer wrap: NumReq-1 → 0.
  - Write-after-read to the same address in the same cycle: never co-granted.

## Test plan

- **Reset:** hold `rst_i`=1 for 3 cycles with all `req_valid_i`=1111. Required: `req_ready_o`=0000 and `ram_we_*`/`ram_re_*`=0. On the first cycle after release, grants go to r0 (A) and r1 (B).
- **Round-robin:** all 4 requesters issue continuous reads to distinct addresses, Pipelined=0. Required grant pairs per cycle: (0,1), (2,3), (0,1), …. Each requester gets a response every other cycle, exactly 1 cycle after its grant.
- **Conflict:** r0 writes 0x0010 with 0xDEADBEEF while r1 reads 0x0010 and r2 reads 0x0020. Required: A=r0, B=r2, r1 stalls. Next cycle r1 is granted and receives 0xDEADBEEF one cycle later.
- **Shared read:** r0 and r1 both read 0x0005, preloaded with 0x12345678. Required: both granted in the same cycle; both `rsp_valid_o` bits pulse together with 0x12345678.
- **Latency:** Pipelined=1, r3 reads 0x00FF at cycle T. Required: `rsp_valid_o[3]` pulses only at T+2 with the stored data. Two back-to-back reads from r3 return in order at T+2 and T+3.
- **Reset mid-flight:** assert `rst_i` one cycle after a read grant with Pipelined=1. Required: no `rsp_valid_o` pulse afterwards, and `ptr` restarts at 0.
